// File: rtl/acq_pkg.sv
// -----------------------------------------------------------------------------
// acq_pkg
// Shared definitions for the acquisition sequencer:
//   - acq_state_e      : sequencer state encoding (IDLE/DELAY/CAPTURE/READOUT)
//   - CNT_W_DEF        : default width of sample/word/delay counts
//   - ADDR_W_DEF       : default sample-buffer address width
//   - CTRL_REG_TRIG    : control-register index carrying trig_start (bit 0)
//   - CTRL_REG_SOFT_RST: control-register index carrying soft_rst (bit 0)
// No ports.
// -----------------------------------------------------------------------------
package acq_pkg;

  localparam int CNT_W_DEF         = 16;
  localparam int ADDR_W_DEF        = 12;
  localparam int CTRL_REG_TRIG     = 10;
  localparam int CTRL_REG_SOFT_RST = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    CAPTURE = 2'd2,
    READOUT = 2'd3
  } acq_state_e;

endpackage

// File: rtl/acq_edge_det.sv
// -----------------------------------------------------------------------------
// acq_edge_det
// One-flop rising-edge detector.
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset (delayed copy resets to 0)
//   i_sig   in   level to watch
//   o_rise  out  high in any cycle where i_sig is 1 and was 0 last cycle
// -----------------------------------------------------------------------------
module acq_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig_q <= 1'b0;
    end else begin
      r_sig_q <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/acq_sequencer.sv
// -----------------------------------------------------------------------------
// acq_sequencer
// Runs one ADC acquisition: trigger edge -> programmable delay -> capture of
// sample_num samples into the sample buffer -> readout of word_num words to
// the SPI transmit path, paced by spi_done.
// Optional build macro: ACQ_TIMESTAMP_EN adds trig_ts (32-bit sysclk count
// latched at each accepted trigger edge).
// Ports:
//   sysclk       in   system clock
//   rst_n        in   asynchronous active-low reset
//   soft_rst     in   synchronous abort (level, active-high)
//   trig_start   in   trigger level; rising edge starts an acquisition
//   sample_num   in   samples to capture
//   word_num     in   words to read out
//   trig_delay   in   cycles between trigger and first capture
//   spi_done     in   one-cycle pulse per completed SPI word
//   cap_en       out  capture-buffer write enable
//   cap_addr     out  capture-buffer write address
//   rd_en        out  one-cycle readout strobe
//   rd_addr      out  readout address
//   busy         out  high whenever not IDLE
//   acq_done     out  one-cycle pulse when an acquisition completes
//   trig_missed  out  sticky: trigger edge arrived while busy
//   trig_ts      out  (ACQ_TIMESTAMP_EN only) timestamp of last accepted edge
// -----------------------------------------------------------------------------
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              soft_rst,
  input  logic              trig_start,
  input  logic [CNT_W-1:0]  sample_num,
  input  logic [CNT_W-1:0]  word_num,
  input  logic [CNT_W-1:0]  trig_delay,
  input  logic              spi_done,
  output logic              cap_en,
  output logic [ADDR_W-1:0] cap_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              acq_done,
  output logic              trig_missed
`ifdef ACQ_TIMESTAMP_EN
  ,
  output logic [31:0]       trig_ts
`endif
);

  acq_state_e        r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next, w_cnt_inc;
  logic [CNT_W-1:0]  r_sample_num, r_word_num, r_delay;
  logic [ADDR_W-1:0] r_cap_addr, w_cap_addr_next;
  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_next;
  logic              r_rd_en, w_rd_en_next;
  logic              r_acq_done, w_acq_done_next;
  logic              r_trig_missed, w_trig_missed_next;
  logic              w_edge, w_accept;

  acq_edge_det u_trig_edge (
    .clk    (sysclk),
    .rst_n  (rst_n),
    .i_sig  (trig_start),
    .o_rise (w_edge)
  );

  assign w_cnt_inc = r_cnt + 1'b1;

  // r_cnt is shared: delay cycles in DELAY, samples written in CAPTURE,
  // rd_en pulses issued in READOUT.
  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_cap_addr_next    = r_cap_addr;
    w_rd_addr_next     = r_rd_addr;
    w_rd_en_next       = 1'b0;
    w_acq_done_next    = 1'b0;
    w_trig_missed_next = r_trig_missed;
    w_accept           = 1'b0;

    if (soft_rst) begin
      // Abort: any coincident trigger edge is dropped along with the run.
      w_state_next       = IDLE;
      w_trig_missed_next = 1'b0;
    end else begin
      if (w_edge && (r_state != IDLE)) begin
        w_trig_missed_next = 1'b1;
      end

      unique case (r_state)
        IDLE: begin
          if (w_edge) begin
            w_accept        = 1'b1;
            w_state_next    = DELAY;
            w_cnt_next      = '0;
            w_cap_addr_next = '0;
            w_rd_addr_next  = '0;
          end
        end

        DELAY: begin
          if (r_cnt == r_delay) begin
            w_cnt_next = '0;
            if (r_sample_num != '0) begin
              w_state_next = CAPTURE;
            end else if (r_word_num != '0) begin
              // Entry strobe preloads word 0 and counts as the first pulse.
              w_state_next = READOUT;
              w_rd_en_next = 1'b1;
              w_cnt_next   = CNT_W'(1);
            end else begin
              w_state_next    = IDLE;
              w_acq_done_next = 1'b1;
            end
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end

        CAPTURE: begin
          w_cap_addr_next = r_cap_addr + 1'b1;
          w_cnt_next      = w_cnt_inc;
          if (w_cnt_inc == r_sample_num) begin
            if (r_word_num != '0) begin
              w_state_next = READOUT;
              w_rd_en_next = 1'b1;
              w_cnt_next   = CNT_W'(1);
            end else begin
              w_state_next    = IDLE;
              w_acq_done_next = 1'b1;
            end
          end
        end

        READOUT: begin
          if (spi_done) begin
            if (r_cnt == r_word_num) begin
              w_state_next    = IDLE;
              w_acq_done_next = 1'b1;
            end else begin
              w_rd_addr_next = r_rd_addr + 1'b1;
              w_rd_en_next   = 1'b1;
              w_cnt_next     = w_cnt_inc;
            end
          end
        end

        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_sample_num  <= '0;
      r_word_num    <= '0;
      r_delay       <= '0;
      r_cap_addr    <= '0;
      r_rd_addr     <= '0;
      r_rd_en       <= 1'b0;
      r_acq_done    <= 1'b0;
      r_trig_missed <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_cap_addr    <= w_cap_addr_next;
      r_rd_addr     <= w_rd_addr_next;
      r_rd_en       <= w_rd_en_next;
      r_acq_done    <= w_acq_done_next;
      r_trig_missed <= w_trig_missed_next;
      if (w_accept) begin
        r_sample_num <= sample_num;
        r_word_num   <= word_num;
        r_delay      <= trig_delay;
      end
    end
  end

  // soft_rst masks the strobes combinationally so they drop in the same cycle.
  assign cap_en      = (r_state == CAPTURE) & ~soft_rst;
  assign rd_en       = r_rd_en & ~soft_rst;
  assign cap_addr    = r_cap_addr;
  assign rd_addr     = r_rd_addr;
  assign busy        = (r_state != IDLE);
  assign acq_done    = r_acq_done;
  assign trig_missed = r_trig_missed;

`ifdef ACQ_TIMESTAMP_EN
  logic [31:0] r_ts_cnt, r_trig_ts;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts_cnt  <= '0;
      r_trig_ts <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 32'd1;
      if (w_accept) begin
        r_trig_ts <= r_ts_cnt;
      end
    end
  end

  assign trig_ts = r_trig_ts;
`endif

endmodule

// File: tb/tb_acq_sequencer.sv
// -----------------------------------------------------------------------------
// tb_acq_sequencer
// Scoreboard bench for acq_sequencer. Two instances share all stimulus:
// u_dut with ADDR_W=2 (address wrap) and u_dut_w with default parameters.
// Expected capture/readout/done events (cycle + address) are queued when the
// stimulus is driven and popped by a negedge monitor.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_acq_sequencer;

  localparam int CW = 16;

  logic          sysclk;
  logic          rst_n;
  logic          soft_rst;
  logic          trig_start;
  logic [CW-1:0] sample_num;
  logic [CW-1:0] word_num;
  logic [CW-1:0] trig_delay;
  logic          spi_done;

  logic          cap_en, rd_en, busy, acq_done, trig_missed;
  logic [1:0]    cap_addr, rd_addr;
  logic          cap_en_w, rd_en_w, busy_w, acq_done_w, trig_missed_w;
  logic [11:0]   cap_addr_w, rd_addr_w;

  acq_sequencer #(.CNT_W(CW), .ADDR_W(2)) u_dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .soft_rst    (soft_rst),
    .trig_start  (trig_start),
    .sample_num  (sample_num),
    .word_num    (word_num),
    .trig_delay  (trig_delay),
    .spi_done    (spi_done),
    .cap_en      (cap_en),
    .cap_addr    (cap_addr),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .busy        (busy),
    .acq_done    (acq_done),
    .trig_missed (trig_missed)
  );

  acq_sequencer u_dut_w (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .soft_rst    (soft_rst),
    .trig_start  (trig_start),
    .sample_num  (sample_num),
    .word_num    (word_num),
    .trig_delay  (trig_delay),
    .spi_done    (spi_done),
    .cap_en      (cap_en_w),
    .cap_addr    (cap_addr_w),
    .rd_en       (rd_en_w),
    .rd_addr     (rd_addr_w),
    .busy        (busy_w),
    .acq_done    (acq_done_w),
    .trig_missed (trig_missed_w)
  );

  typedef struct {
    int cyc;
    int addr;
  } ev_t;

  ev_t exp_cap[$];
  ev_t exp_rd[$];
  int  exp_done[$];

  int  cyc;
  int  n_checks;
  int  n_fail;

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  // Trigger is sampled at the next posedge (cycle k); capture i happens in
  // cycle k+d+1+i, readout entry (or done) follows the last capture.
  task automatic start_acq(input int s, input int w, input int d);
    int k;
    k          = cyc + 1;
    sample_num = CW'(s);
    word_num   = CW'(w);
    trig_delay = CW'(d);
    trig_start = 1'b1;
    for (int i = 0; i < s; i++) exp_cap.push_back('{k + d + 1 + i, i});
    if (w != 0) exp_rd.push_back('{k + d + 1 + s, 0});
    else        exp_done.push_back(k + d + 1 + s);
    $display("trigger cyc=%0d samples=%0d words=%0d delay=%0d", k, s, w, d);
  endtask

  task automatic do_spi(input bit want_rd, input int addr, input bit want_done);
    spi_done = 1'b1;
    if (want_rd)   exp_rd.push_back('{cyc + 1, addr});
    if (want_done) exp_done.push_back(cyc + 1);
    tick();
    spi_done = 1'b0;
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy"},     32'(busy), 0);
    check_val({tag, "_cap_en"},   32'(cap_en), 0);
    check_val({tag, "_rd_en"},    32'(rd_en), 0);
    check_val({tag, "_done"},     32'(acq_done), 0);
    check_val({tag, "_missed"},   32'(trig_missed), 0);
    check_val({tag, "_cap_addr"}, 32'(cap_addr_w), 0);
    check_val({tag, "_rd_addr"},  32'(rd_addr_w), 0);
  endtask

  ev_t m_ev;
  int  m_done;

  always @(negedge sysclk) begin
    if (cap_en) begin
      if (exp_cap.size() == 0) begin
        check_val("cap_unexpected", 32'(cap_en), 0);
      end else begin
        m_ev = exp_cap.pop_front();
        check_val("cap_cyc",    cyc, m_ev.cyc);
        check_val("cap_addr",   32'(cap_addr), m_ev.addr % 4);
        check_val("capw_en",    32'(cap_en_w), 1);
        check_val("capw_addr",  32'(cap_addr_w), m_ev.addr % 4096);
        $display("cap  cyc=%0d addr=%0d addr_w=%0d", cyc, cap_addr, cap_addr_w);
      end
    end
    if (rd_en) begin
      if (exp_rd.size() == 0) begin
        check_val("rd_unexpected", 32'(rd_en), 0);
      end else begin
        m_ev = exp_rd.pop_front();
        check_val("rd_cyc",   cyc, m_ev.cyc);
        check_val("rd_addr",  32'(rd_addr), m_ev.addr % 4);
        check_val("rdw_en",   32'(rd_en_w), 1);
        check_val("rdw_addr", 32'(rd_addr_w), m_ev.addr % 4096);
        $display("rd   cyc=%0d addr=%0d", cyc, rd_addr);
      end
    end
    if (acq_done) begin
      if (exp_done.size() == 0) begin
        check_val("done_unexpected", 32'(acq_done), 0);
      end else begin
        m_done = exp_done.pop_front();
        check_val("done_cyc", cyc, m_done);
        $display("done cyc=%0d", cyc);
      end
    end
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    soft_rst   = 1'b0;
    trig_start = 1'b0;
    sample_num = '0;
    word_num   = '0;
    trig_delay = '0;
    spi_done   = 1'b0;

    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Main flow: 4 samples, 3 words, delay 2; config changes after the edge
    // must not affect the run.
    start_acq(4, 3, 2);
    tick();
    trig_start = 1'b0;
    sample_num = 16'd9;
    word_num   = 16'd7;
    trig_delay = 16'd5;
    tick();
    check_val("a_busy", 32'(busy), 1);
    repeat (8) tick();
    do_spi(1'b1, 1, 1'b0);
    do_spi(1'b1, 2, 1'b0);
    do_spi(1'b0, 0, 1'b1);
    tick();
    check_val("a_busy_end", 32'(busy), 0);

    // Zero delay, zero samples, zero words: one DELAY cycle then done.
    start_acq(0, 0, 0);
    tick();
    trig_start = 1'b0;
    check_val("b_busy_delay", 32'(busy), 1);
    tick();
    check_val("b_busy_end", 32'(busy), 0);
    tick();

    // Second edge during CAPTURE is ignored but flagged; addresses wrap.
    start_acq(6, 2, 1);
    tick();
    trig_start = 1'b0;
    repeat (3) tick();
    trig_start = 1'b1;
    tick();
    check_val("c_missed_set", 32'(trig_missed), 1);
    trig_start = 1'b0;
    repeat (6) tick();
    do_spi(1'b1, 1, 1'b0);
    do_spi(1'b0, 0, 1'b1);
    tick();
    check_val("c_missed_hold", 32'(trig_missed), 1);
    check_val("c_busy_end", 32'(busy), 0);
    soft_rst = 1'b1;
    tick();
    check_val("c_missed_clr", 32'(trig_missed), 0);
    soft_rst = 1'b0;
    tick();

    // Edge coincident with soft_rst is dropped.
    soft_rst   = 1'b1;
    trig_start = 1'b1;
    tick();
    check_val("d_coinc_busy", 32'(busy), 0);
    check_val("d_coinc_missed", 32'(trig_missed), 0);
    soft_rst   = 1'b0;
    trig_start = 1'b0;
    tick();

    // soft_rst during READOUT after word 1, hitting a pending rd_en.
    start_acq(2, 3, 0);
    tick();
    trig_start = 1'b0;
    repeat (5) tick();
    do_spi(1'b1, 1, 1'b0);
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    soft_rst = 1'b1;
    #1;
    check_val("d_srst_rd_drop", 32'(rd_en), 0);
    tick();
    check_val("d_srst_busy", 32'(busy), 0);
    soft_rst = 1'b0;
    do_spi(1'b0, 0, 1'b0);
    do_spi(1'b0, 0, 1'b0);
    check_val("d_after_busy", 32'(busy), 0);

    // Async reset at sample 5 of 8.
    start_acq(8, 1, 0);
    tick();
    trig_start = 1'b0;
    tick();
    trig_start = 1'b1;
    tick();
    trig_start = 1'b0;
    check_val("e_missed_set", 32'(trig_missed), 1);
    repeat (4) tick();
    rst_n = 1'b0;
    exp_cap.delete();
    exp_rd.delete();
    exp_done.delete();
    #1;
    check_idle_outputs("e_async");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_val("e_post_busy", 32'(busy), 0);

    // Clean restart after reset.
    start_acq(3, 1, 1);
    tick();
    trig_start = 1'b0;
    repeat (7) tick();
    do_spi(1'b0, 0, 1'b1);
    tick();
    check_val("f_busy_end", 32'(busy), 0);

    repeat (3) tick();
    check_val("left_cap",  exp_cap.size(), 0);
    check_val("left_rd",   exp_rd.size(), 0);
    check_val("left_done", exp_done.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
